ex_mem_pipe: RTL and testbench
==============================

# ex_mem_pipe

Parametrised EX→MEM pipeline register, the successor to the fixed 32-bit EX/MEM latch. It carries the EX result payload (GPR write, HI/LO write, ALU op, memory address, store data, PC, delay-slot flag) into MEM under the global stall vector. It adds a registered valid bit, a synchronous flush for exceptions, and a configurable stage index. Multi-cycle accumulator state (`acc`/`cnt`) loops back to EX across stall cycles, with an optional bubble/hold performance counter.

## Interface
- `DATA_W`, 32, GPR/HI/LO/address width
- `REG_ADDR_W`, 5, register-file address width
- `ALUOP_W`, 8, ALU opcode width
- `CNT_W`, 2, multi-cycle step counter width
- `STALL_W`, 6, stall vector width
- `STAGE`, 3, index of this register's stall bit; `STAGE+1` must be < `STALL_W`
- `NOP_ALUOP`, 0, opcode loaded for bubbles
- `PERF_W`, 16, perf counter width
- `clk  in  1`  clock, all state on rising edge
- `rst  in  1`  asynchronous, active-low reset
- `stall  in  STALL_W`  global stall vector, 1 = stop
- `flush  in  1`  exception flush, synchronous
- `ex_valid  in  1`  EX holds a real instruction
- `ex_wreg  in  1`, `ex_wd  in  REG_ADDR_W`, `ex_wdata  in  DATA_W`  GPR write
- `ex_whilo  in  1`, `ex_hi  in  DATA_W`, `ex_lo  in  DATA_W`  HI/LO write
- `ex_aluop  in  ALUOP_W`, `ex_mem_addr  in  DATA_W`, `ex_reg2  in  DATA_W`  load/store info
- `ex_pc  in  DATA_W`, `ex_in_delayslot  in  1`  exception info
- `acc_i  in  2*DATA_W`, `cnt_i  in  CNT_W`  multi-cycle state from EX
- `mem_*  out`  registered copies of every `ex_*` payload field above, same widths, plus `mem_valid  out  1`
- `acc_o  out  2*DATA_W`, `cnt_o  out  CNT_W`  multi-cycle state back to EX
- `mem_action  out  2`  last action: 0 ADVANCE, 1 BUBBLE, 2 HOLD, 3 FLUSH
- `perf_bubble  out  PERF_W`, `perf_hold  out  PERF_W`  present only with `EX_MEM_PIPE_PERF_EN`

## Operation
The action is evaluated every cycle with strict priority. `s = stall[STAGE]`, `n = stall[STAGE+1]`.
1. **FLUSH** (`flush=1`): all payload cleared. Clear means 0 for every `mem_*` field, `mem_aluop=NOP_ALUOP`, `mem_valid=0`. `acc_o` and `cnt_o` also cleared.
2. **BUBBLE** (`s=1`, `n=0`): payload cleared as in flush. `acc_o<=acc_i`, `cnt_o<=cnt_i`, so EX keeps its partial result.
3. **ADVANCE** (`s=0`): every `mem_*` field takes its `ex_*` value; `mem_valid<=ex_valid`. `acc_o` and `cnt_o` cleared.
4. **HOLD** (`s=1`, `n=1`): payload and `mem_valid` retained. `acc_o<=acc_i`, `cnt_o<=cnt_i`.

Other rules:
- `mem_action` registers the selected action code each cycle.
- Reset, asynchronous on `rst=0`: all outputs 0, except `mem_aluop=NOP_ALUOP` and `mem_action=ADVANCE`. Perf counters are 0.
- Reset mid-multi-cycle op discards `acc`/`cnt` immediately; no partial result survives.
- `flush` during HOLD still clears; flush dominates every stall combination.
- Payload is a pure register: no arithmetic, no width conversion.

## Timing
- Latency: `ex_*` appears on `mem_*` 1 cycle after a cycle with `s=0` and `flush=0`.
- `acc`/`cnt` loop: a value presented in a stalled cycle is returned on `acc_o`/`cnt_o` the next cycle, and is zero the cycle after an advance.
- Stall vector and flush are sampled at the same edge. No combinational path exists from any input to any output.
- Back-to-back advances sustain one instruction per cycle.

## Configuration
- `EX_MEM_PIPE_PERF_EN` defined:
  - `perf_bubble` increments on each BUBBLE cycle, `perf_hold` on each HOLD cycle.
  - Both counters saturate at all-ones and do not wrap.
  - Both counters are cleared only by reset, never by flush.
- `EX_MEM_PIPE_PERF_EN` undefined: both counters and their ports are absent, and no perf logic is generated.

## Test plan
- **Reset**:
  - Drive `rst=0` asynchronously mid-cycle with `s=0` and live payload → all outputs 0 and `mem_aluop=NOP_ALUOP` before the next edge.
  - Hold `rst=0` → outputs stay 0.
- **Advance**: `ex_wd=5`, `ex_wdata=0xDEADBEEF`, `ex_valid=1`, `stall=0` → next cycle `mem_wd=5`, `mem_wdata=0xDEADBEEF`, `mem_valid=1`, `acc_o=0`, `mem_action=0`.
- **Bubble with accumulator**: `stall=6'b001111`, `acc_i=0x1_0000_0002`, `cnt_i=1` → `mem_valid=0`, `mem_wreg=0`, `acc_o=0x1_0000_0002`, `cnt_o=1`, `mem_action=1`.
- **Hold**:
  - Load payload with `mem_wdata=0x12`, then `stall=6'b011111` for 3 cycles → `mem_wdata` stays `0x12`, `mem_valid` stays 1, `mem_action=2`.
  - With perf enabled → `perf_hold=3`.
- **Flush priority**: `flush=1` together with `stall=6'b011111` and valid payload → next cycle `mem_valid=0`, `mem_aluop=NOP_ALUOP`, `acc_o=0`, `mem_action=3`.
- **Perf saturation**: `PERF_W=2`, 5 consecutive bubbles → `perf_bubble=3` and stays 3; a following flush leaves it at 3.

Source files
------------

// File: rtl/ex_mem_pipe_if.sv
// EX->MEM pipeline bus: EX-side payload and multi-cycle state toward the register,
// registered MEM-side payload and looped-back multi-cycle state out of it.
interface ex_mem_pipe_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int CNT_W      = 2
);
  logic                  ex_valid;
  logic                  ex_wreg;
  logic [REG_ADDR_W-1:0] ex_wd;
  logic [DATA_W-1:0]     ex_wdata;
  logic                  ex_whilo;
  logic [DATA_W-1:0]     ex_hi;
  logic [DATA_W-1:0]     ex_lo;
  logic [ALUOP_W-1:0]    ex_aluop;
  logic [DATA_W-1:0]     ex_mem_addr;
  logic [DATA_W-1:0]     ex_reg2;
  logic [DATA_W-1:0]     ex_pc;
  logic                  ex_in_delayslot;
  logic [2*DATA_W-1:0]   acc_i;
  logic [CNT_W-1:0]      cnt_i;

  logic                  mem_valid;
  logic                  mem_wreg;
  logic [REG_ADDR_W-1:0] mem_wd;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_whilo;
  logic [DATA_W-1:0]     mem_hi;
  logic [DATA_W-1:0]     mem_lo;
  logic [ALUOP_W-1:0]    mem_aluop;
  logic [DATA_W-1:0]     mem_mem_addr;
  logic [DATA_W-1:0]     mem_reg2;
  logic [DATA_W-1:0]     mem_pc;
  logic                  mem_in_delayslot;
  logic [2*DATA_W-1:0]   acc_o;
  logic [CNT_W-1:0]      cnt_o;

  modport master (
    output ex_valid, ex_wreg, ex_wd, ex_wdata, ex_whilo, ex_hi, ex_lo,
           ex_aluop, ex_mem_addr, ex_reg2, ex_pc, ex_in_delayslot, acc_i, cnt_i,
    input  mem_valid, mem_wreg, mem_wd, mem_wdata, mem_whilo, mem_hi, mem_lo,
           mem_aluop, mem_mem_addr, mem_reg2, mem_pc, mem_in_delayslot, acc_o, cnt_o
  );

  modport slave (
    input  ex_valid, ex_wreg, ex_wd, ex_wdata, ex_whilo, ex_hi, ex_lo,
           ex_aluop, ex_mem_addr, ex_reg2, ex_pc, ex_in_delayslot, acc_i, cnt_i,
    output mem_valid, mem_wreg, mem_wd, mem_wdata, mem_whilo, mem_hi, mem_lo,
           mem_aluop, mem_mem_addr, mem_reg2, mem_pc, mem_in_delayslot, acc_o, cnt_o
  );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with valid bit, flush, stall-driven bubble/hold and acc/cnt loopback.
// Optional saturating bubble/hold counters when EX_MEM_PIPE_PERF_EN is defined.
module ex_mem_pipe #(
  parameter int                 DATA_W     = 32,
  parameter int                 REG_ADDR_W = 5,
  parameter int                 ALUOP_W    = 8,
  parameter int                 CNT_W      = 2,
  parameter int                 STALL_W    = 6,
  parameter int                 STAGE      = 3,
  parameter logic [ALUOP_W-1:0] NOP_ALUOP  = '0,
  parameter int                 PERF_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  ex_mem_pipe_if.slave       bus,
  output logic [1:0]         mem_action
`ifdef EX_MEM_PIPE_PERF_EN
  ,
  output logic [PERF_W-1:0]  perf_bubble,
  output logic [PERF_W-1:0]  perf_hold
`endif
);

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_HOLD    = 2'd2,
    ACT_FLUSH   = 2'd3
  } action_e;

  typedef struct packed {
    logic                  wreg;
    logic [REG_ADDR_W-1:0] wd;
    logic [DATA_W-1:0]     wdata;
    logic                  whilo;
    logic [DATA_W-1:0]     hi;
    logic [DATA_W-1:0]     lo;
    logic [ALUOP_W-1:0]    aluop;
    logic [DATA_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     reg2;
    logic [DATA_W-1:0]     pc;
    logic                  in_delayslot;
  } payload_t;

  localparam payload_t PL_CLEAR = '{aluop: NOP_ALUOP, default: '0};

  payload_t            ex_pl, pl_d, pl_q;
  logic                valid_d, valid_q;
  logic [2*DATA_W-1:0] acc_d, acc_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  action_e             action_d, action_q;
  logic                stall_s, stall_n;
  logic                stall_unused;

  assign stall_s = stall[STAGE];
  assign stall_n = stall[STAGE+1];
  // Bits belonging to other pipeline stages are deliberately ignored here.
  assign stall_unused = ^stall;

  assign ex_pl = '{
    wreg:         bus.ex_wreg,
    wd:           bus.ex_wd,
    wdata:        bus.ex_wdata,
    whilo:        bus.ex_whilo,
    hi:           bus.ex_hi,
    lo:           bus.ex_lo,
    aluop:        bus.ex_aluop,
    mem_addr:     bus.ex_mem_addr,
    reg2:         bus.ex_reg2,
    pc:           bus.ex_pc,
    in_delayslot: bus.ex_in_delayslot
  };

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    action_d = ACT_HOLD;
    pl_d     = pl_q;
    valid_d  = valid_q;
    acc_d    = bus.acc_i;
    cnt_d    = bus.cnt_i;
    if (flush) begin
      action_d = ACT_FLUSH;
      pl_d     = PL_CLEAR;
      valid_d  = 1'b0;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (!stall_s) begin
      action_d = ACT_ADVANCE;
      pl_d     = ex_pl;
      valid_d  = bus.ex_valid;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (!stall_n) begin
      // Downstream is free but EX is not: insert a bubble, EX keeps its partial result.
      action_d = ACT_BUBBLE;
      pl_d     = PL_CLEAR;
      valid_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pl_q     <= PL_CLEAR;
      valid_q  <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      action_q <= ACT_ADVANCE;
    end else begin
      pl_q     <= pl_d;
      valid_q  <= valid_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      action_q <= action_d;
    end
  end

  assign bus.mem_valid        = valid_q;
  assign bus.mem_wreg         = pl_q.wreg;
  assign bus.mem_wd           = pl_q.wd;
  assign bus.mem_wdata        = pl_q.wdata;
  assign bus.mem_whilo        = pl_q.whilo;
  assign bus.mem_hi           = pl_q.hi;
  assign bus.mem_lo           = pl_q.lo;
  assign bus.mem_aluop        = pl_q.aluop;
  assign bus.mem_mem_addr     = pl_q.mem_addr;
  assign bus.mem_reg2         = pl_q.reg2;
  assign bus.mem_pc           = pl_q.pc;
  assign bus.mem_in_delayslot = pl_q.in_delayslot;
  assign bus.acc_o            = acc_q;
  assign bus.cnt_o            = cnt_q;
  assign mem_action           = action_q;

`ifdef EX_MEM_PIPE_PERF_EN
  logic [PERF_W-1:0] perf_bubble_d, perf_bubble_q;
  logic [PERF_W-1:0] perf_hold_d, perf_hold_q;

  // Saturating counters; flush does not clear them, only reset does.
  always_comb begin
    perf_bubble_d = perf_bubble_q;
    perf_hold_d   = perf_hold_q;
    if (action_d == ACT_BUBBLE && perf_bubble_q != '1) perf_bubble_d = perf_bubble_q + PERF_W'(1);
    if (action_d == ACT_HOLD && perf_hold_q != '1)     perf_hold_d   = perf_hold_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_bubble_q <= '0;
      perf_hold_q   <= '0;
    end else begin
      perf_bubble_q <= perf_bubble_d;
      perf_hold_q   <= perf_hold_d;
    end
  end

  assign perf_bubble = perf_bubble_q;
  assign perf_hold   = perf_hold_q;
`else
  logic [PERF_W-1:0] perf_unused;
  assign perf_unused = '0;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: directed scenarios then randomized traffic against
// a rule-level reference model (honours EX_MEM_PIPE_PERF_EN when defined).
module tb_ex_mem_pipe;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 8;
  localparam int CNT_W      = 2;
  localparam int STALL_W    = 6;
  localparam int STAGE      = 3;
  localparam logic [ALUOP_W-1:0] NOP = 8'hA5;
`ifdef EX_MEM_PIPE_PERF_EN
  localparam int PERF_W = 2;
`else
  localparam int PERF_W = 16;
`endif

  logic               clk;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [1:0]         mem_action;
`ifdef EX_MEM_PIPE_PERF_EN
  logic [PERF_W-1:0]  perf_bubble, perf_hold;
`endif

  ex_mem_pipe_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

  ex_mem_pipe #(
    .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W),
    .STALL_W(STALL_W), .STAGE(STAGE), .NOP_ALUOP(NOP), .PERF_W(PERF_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .flush(flush),
    .bus(bus),
    .mem_action(mem_action)
`ifdef EX_MEM_PIPE_PERF_EN
    ,
    .perf_bubble(perf_bubble),
    .perf_hold(perf_hold)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        valid, wreg, whilo, ds;
    logic [4:0]  wd;
    logic [31:0] wdata, hi, lo, addr, reg2, pc;
    logic [7:0]  aluop;
  } pl_t;

  pl_t         exp_pl;
  logic [63:0] exp_acc;
  logic [1:0]  exp_cnt;
  int          exp_act;
  int          exp_pb, exp_ph;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pl_t cleared();
    pl_t p = '{default: '0};
    p.aluop = NOP;
    return p;
  endfunction

  function automatic pl_t from_ex();
    pl_t p;
    p.valid = bus.ex_valid;       p.wreg  = bus.ex_wreg;   p.wd   = bus.ex_wd;
    p.wdata = bus.ex_wdata;       p.whilo = bus.ex_whilo;  p.hi   = bus.ex_hi;
    p.lo    = bus.ex_lo;          p.aluop = bus.ex_aluop;  p.addr = bus.ex_mem_addr;
    p.reg2  = bus.ex_reg2;        p.pc    = bus.ex_pc;     p.ds   = bus.ex_in_delayslot;
    return p;
  endfunction

  task automatic model_reset();
    exp_pl = cleared(); exp_acc = '0; exp_cnt = '0; exp_act = 0; exp_pb = 0; exp_ph = 0;
  endtask

  // Next-state rules: flush beats everything, then advance, then bubble, else hold.
  task automatic model_update();
    bit s = stall[STAGE];
    bit n = stall[STAGE+1];
    int max = (1 << PERF_W) - 1;
    if (flush) begin
      exp_pl = cleared(); exp_acc = '0; exp_cnt = '0; exp_act = 3;
    end else if (!s) begin
      exp_pl = from_ex(); exp_acc = '0; exp_cnt = '0; exp_act = 0;
    end else if (!n) begin
      exp_pl = cleared(); exp_acc = bus.acc_i; exp_cnt = bus.cnt_i; exp_act = 1;
      if (exp_pb < max) exp_pb++;
    end else begin
      exp_acc = bus.acc_i; exp_cnt = bus.cnt_i; exp_act = 2;
      if (exp_ph < max) exp_ph++;
    end
  endtask

  task automatic check_all();
    check("mem_valid", bus.mem_valid, exp_pl.valid);
    check("mem_wreg", bus.mem_wreg, exp_pl.wreg);
    check("mem_wd", bus.mem_wd, exp_pl.wd);
    check("mem_wdata", bus.mem_wdata, exp_pl.wdata);
    check("mem_whilo", bus.mem_whilo, exp_pl.whilo);
    check("mem_hi", bus.mem_hi, exp_pl.hi);
    check("mem_lo", bus.mem_lo, exp_pl.lo);
    check("mem_aluop", bus.mem_aluop, exp_pl.aluop);
    check("mem_mem_addr", bus.mem_mem_addr, exp_pl.addr);
    check("mem_reg2", bus.mem_reg2, exp_pl.reg2);
    check("mem_pc", bus.mem_pc, exp_pl.pc);
    check("mem_in_delayslot", bus.mem_in_delayslot, exp_pl.ds);
    check("acc_o", bus.acc_o, exp_acc);
    check("cnt_o", bus.cnt_o, exp_cnt);
    check("mem_action", mem_action, exp_act[1:0]);
`ifdef EX_MEM_PIPE_PERF_EN
    check("perf_bubble", perf_bubble, exp_pb[PERF_W-1:0]);
    check("perf_hold", perf_hold, exp_ph[PERF_W-1:0]);
`endif
  endtask

  // One clock: model follows the inputs present at the edge, outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset(); else model_update();
    #1;
    check_all();
  endtask

  task automatic randomize_ex();
    bus.ex_valid = 1'($urandom);          bus.ex_wreg  = 1'($urandom);
    bus.ex_wd    = 5'($urandom);          bus.ex_wdata = $urandom;
    bus.ex_whilo = 1'($urandom);          bus.ex_hi    = $urandom;
    bus.ex_lo    = $urandom;              bus.ex_aluop = 8'($urandom);
    bus.ex_mem_addr = $urandom;           bus.ex_reg2  = $urandom;
    bus.ex_pc    = $urandom;              bus.ex_in_delayslot = 1'($urandom);
    bus.acc_i    = {$urandom, $urandom};  bus.cnt_i    = 2'($urandom);
  endtask

  initial begin
    rst = 1'b0; stall = '0; flush = 1'b0;
    randomize_ex();
    model_reset();
    repeat (2) tick();
    #2 rst = 1'b1;

    // Advance
    randomize_ex();
    bus.ex_wd = 5'd5; bus.ex_wdata = 32'hDEADBEEF; bus.ex_valid = 1'b1; stall = '0;
    tick();
    check("adv_wd", bus.mem_wd, 5);
    check("adv_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("adv_valid", bus.mem_valid, 1);
    check("adv_acc", bus.acc_o, 0);
    check("adv_action", mem_action, 0);

    // Bubble with accumulator
    randomize_ex();
    stall = 6'b001111; bus.acc_i = 64'h1_0000_0002; bus.cnt_i = 2'd1;
    tick();
    check("bub_valid", bus.mem_valid, 0);
    check("bub_wreg", bus.mem_wreg, 0);
    check("bub_acc", bus.acc_o, 64'h1_0000_0002);
    check("bub_cnt", bus.cnt_o, 1);
    check("bub_action", mem_action, 1);

    // Hold for three cycles after loading 0x12
    randomize_ex();
    stall = '0; bus.ex_wdata = 32'h12; bus.ex_valid = 1'b1;
    tick();
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      randomize_ex();
      tick();
      check("hold_wdata", bus.mem_wdata, 32'h12);
      check("hold_valid", bus.mem_valid, 1);
      check("hold_action", mem_action, 2);
    end
`ifdef EX_MEM_PIPE_PERF_EN
    check("hold_perf", perf_hold, 3);
`endif

    // Flush dominates a hold
    randomize_ex();
    stall = 6'b011111; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", bus.mem_valid, 0);
    check("flush_aluop", bus.mem_aluop, NOP);
    check("flush_acc", bus.acc_o, 0);
    check("flush_action", mem_action, 3);

    // Five bubbles then a flush (saturation when perf counters present)
    stall = 6'b001111;
    for (int i = 0; i < 5; i++) begin
      randomize_ex();
      tick();
    end
`ifdef EX_MEM_PIPE_PERF_EN
    check("sat_bubble", perf_bubble, 3);
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
`ifdef EX_MEM_PIPE_PERF_EN
    check("sat_after_flush", perf_bubble, 3);
`endif

    // Back-to-back advances
    stall = '0;
    for (int i = 0; i < 10; i++) begin
      randomize_ex();
      tick();
    end

    // A stalled multi-cycle step, then asynchronous reset mid-cycle
    randomize_ex();
    stall = 6'b011111;
    tick();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst_aluop", bus.mem_aluop, NOP);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_acc", bus.acc_o, 0);
    randomize_ex();
    stall = '0;
    tick();
    check("rst_hold_valid", bus.mem_valid, 0);
    #2 rst = 1'b1;

    // Randomized traffic with an occasional asynchronous reset
    for (int i = 0; i < 400; i++) begin
      randomize_ex();
      stall = STALL_W'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      if (i == 200) begin
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rst = 1'b1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
